// File: rtl/axis_sample_packer_pkg.sv
// rtl/axis_sample_packer_pkg.sv - shared lane constants, sizing helpers and parameter checks for axis_sample_packer
package axis_sample_packer_pkg;

    localparam int LANE_W = 16;

    typedef enum logic {
        SER_IDLE = 1'b0,
        SER_BUSY = 1'b1
    } ser_state_e;

    function automatic int spb(input int axis_w);
        return axis_w / LANE_W;
    endfunction

    function automatic int beats_per_set(input int num_ch, input int axis_w);
        return num_ch / spb(axis_w);
    endfunction

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int width_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int num_ch, input int sample_w, input int axis_w,
                                     input int fifo_depth, input int burst_len);
        return (axis_w == 32 || axis_w == 64) &&
               (num_ch > 0) && (num_ch % spb(axis_w) == 0) &&
               (sample_w >= 1) && (sample_w <= LANE_W) &&
               (fifo_depth >= 2) && ((fifo_depth & (fifo_depth - 1)) == 0) &&
               (burst_len >= 1);
    endfunction

endpackage

// File: rtl/axis_sample_packer_fifo.sv
// rtl/axis_sample_packer_fifo.sv - sample_set_fifo: synchronous sample-set FIFO with level and look-ahead read
module sample_set_fifo
    import axis_sample_packer_pkg::*;
#(
    parameter int WIDTH = 96,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       async_resetn,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           rd_data,
    output logic [WIDTH-1:0]           rd_data_next,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = level_w(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [LW-1:0]    count;

    assign rd_ptr_next = rd_ptr + 1'b1;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= wr_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr_next;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // The serializer reads the head in place and uses the next entry to chain sets without a bubble.
    assign rd_data      = mem[rd_ptr];
    assign rd_data_next = mem[rd_ptr_next];
    assign full         = (count == LW'(DEPTH));
    assign empty        = (count == '0);
    assign level        = count;

endmodule

// File: rtl/axis_sample_packer.sv
// rtl/axis_sample_packer.sv - async ADC sample sets to AXI-Stream: sync, decimate, buffer, pack, burst TLAST
// Optional AXIS_SAMPLE_PACKER_TEST_PATTERN_EN adds pattern_mode and per-channel ramp sources.
module axis_sample_packer
    import axis_sample_packer_pkg::*;
#(
    parameter int NUM_CH     = 8,
    parameter int SAMPLE_W   = 12,
    parameter int AXIS_W     = 32,
    parameter int FIFO_DEPTH = 16,
    parameter int BURST_LEN  = 256
) (
    input  logic                          clk,
    input  logic                          async_resetn,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [7:0]                    decim,
    input  logic [NUM_CH*SAMPLE_W-1:0]    src_data,
    input  logic                          src_strobe,
`ifdef AXIS_SAMPLE_PACKER_TEST_PATTERN_EN
    input  logic                          pattern_mode,
`endif
    output logic [AXIS_W-1:0]             m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready,
    output logic                          m_axis_tlast,
    output logic [31:0]                   frame_count,
    output logic [31:0]                   overflow_count,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

    localparam int SET_W   = NUM_CH * SAMPLE_W;
    localparam int SPB_L   = spb(AXIS_W);
    localparam int BEATS   = beats_per_set(NUM_CH, AXIS_W);
    localparam int BEAT_W  = width_min1(BEATS);
    localparam int BURST_W = width_min1(BURST_LEN);
    localparam int LVL_W   = level_w(FIFO_DEPTH);
    localparam logic [BEAT_W-1:0]  LAST_BEAT = BEAT_W'(BEATS - 1);
    localparam logic [BURST_W-1:0] LAST_SET  = BURST_W'(BURST_LEN - 1);

    if (!params_ok(NUM_CH, SAMPLE_W, AXIS_W, FIFO_DEPTH, BURST_LEN)) begin : g_param_check
        $error("axis_sample_packer: illegal parameter combination");
    end

    (* ASYNC_REG = "TRUE" *) logic strobe_meta;
    (* ASYNC_REG = "TRUE" *) logic strobe_sync;
    logic strobe_prev;
    logic edge_pulse;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            strobe_meta <= 1'b0;
            strobe_sync <= 1'b0;
            strobe_prev <= 1'b0;
            edge_pulse  <= 1'b0;
        end else begin
            strobe_meta <= src_strobe;
            strobe_sync <= strobe_meta;
            strobe_prev <= strobe_sync;
            edge_pulse  <= strobe_sync & ~strobe_prev;
        end
    end

    logic [SET_W-1:0] set_source;

`ifdef AXIS_SAMPLE_PACKER_TEST_PATTERN_EN
    logic [SET_W-1:0] ramp;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ramp[k*SAMPLE_W +: SAMPLE_W] <= SAMPLE_W'(k);
            end
        end else if (edge_pulse) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ramp[k*SAMPLE_W +: SAMPLE_W] <= ramp[k*SAMPLE_W +: SAMPLE_W] + 1'b1;
            end
        end
    end

    assign set_source = pattern_mode ? ramp : src_data;
`else
    assign set_source = src_data;
`endif

    // decim is sampled only when dc sits at 0, so a mid-period change waits for the next wrap.
    logic [7:0]       dc;
    logic [7:0]       decim_q;
    logic [7:0]       dc_limit;
    logic             cap_valid;
    logic [SET_W-1:0] cap_data;

    assign dc_limit = (dc == 8'd0) ? decim : decim_q;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            dc        <= 8'd0;
            decim_q   <= 8'd0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
        end else if (clear) begin
            dc        <= 8'd0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= edge_pulse & enable & (dc == 8'd0);
            if (edge_pulse) begin
                if (dc == 8'd0) begin
                    decim_q <= decim;
                end
                dc <= (dc == dc_limit) ? 8'd0 : dc + 1'b1;
                if (enable && dc == 8'd0) begin
                    cap_data <= set_source;
                end
            end
        end
    end

    logic             fifo_full;
    logic             fifo_empty;
    logic             push;
    logic             pop;
    logic [SET_W-1:0] head;
    logic [SET_W-1:0] head_next;

    assign push = cap_valid & ~fifo_full & ~clear;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            frame_count    <= 32'd0;
            overflow_count <= 32'd0;
        end else if (clear) begin
            frame_count    <= 32'd0;
            overflow_count <= 32'd0;
        end else if (cap_valid) begin
            frame_count <= frame_count + 32'd1;
            if (fifo_full) begin
                overflow_count <= overflow_count + 32'd1;
            end
        end
    end

    sample_set_fifo #(
        .WIDTH (SET_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .async_resetn (async_resetn),
        .clear        (clear),
        .wr_en        (push),
        .wr_data      (cap_data),
        .rd_en        (pop),
        .rd_data      (head),
        .rd_data_next (head_next),
        .full         (fifo_full),
        .empty        (fifo_empty),
        .level        (fifo_level)
    );

    function automatic logic [AXIS_W-1:0] pack_beat(input logic [SET_W-1:0] set,
                                                    input logic [BEAT_W-1:0] beat_idx);
        logic [AXIS_W-1:0] word;
        logic [LANE_W-1:0] lane;
        word = '0;
        for (int j = 0; j < SPB_L; j++) begin
            lane = '0;
            lane[LANE_W-1 -: SAMPLE_W] = set[(int'(beat_idx) * SPB_L + j) * SAMPLE_W +: SAMPLE_W];
            word[j*LANE_W +: LANE_W] = lane;
        end
        return word;
    endfunction

    ser_state_e         ser_state;
    logic [BEAT_W-1:0]  beat;
    logic [BEAT_W-1:0]  beat_inc;
    logic [BURST_W-1:0] burst;
    logic [BURST_W-1:0] burst_next;

    assign beat_inc   = beat + 1'b1;
    assign burst_next = (burst == LAST_SET) ? '0 : burst + 1'b1;
    assign pop        = (ser_state == SER_BUSY) & m_axis_tready & (beat == LAST_BEAT) & ~clear;

    always_ff @(posedge clk or negedge async_resetn) begin
        if (!async_resetn) begin
            ser_state    <= SER_IDLE;
            beat         <= '0;
            burst        <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else if (clear) begin
            ser_state    <= SER_IDLE;
            beat         <= '0;
            burst        <= '0;
            m_axis_tdata <= '0;
            m_axis_tlast <= 1'b0;
        end else begin
            case (ser_state)
                SER_IDLE: begin
                    if (!fifo_empty) begin
                        ser_state    <= SER_BUSY;
                        beat         <= '0;
                        m_axis_tdata <= pack_beat(head, '0);
                        m_axis_tlast <= (LAST_BEAT == '0) && (burst == LAST_SET);
                    end
                end
                SER_BUSY: begin
                    if (m_axis_tready) begin
                        if (beat != LAST_BEAT) begin
                            beat         <= beat_inc;
                            m_axis_tdata <= pack_beat(head, beat_inc);
                            m_axis_tlast <= (beat_inc == LAST_BEAT) && (burst == LAST_SET);
                        end else begin
                            beat  <= '0;
                            burst <= burst_next;
                            if (fifo_level > LVL_W'(1)) begin
                                m_axis_tdata <= pack_beat(head_next, '0);
                                m_axis_tlast <= (LAST_BEAT == '0) && (burst_next == LAST_SET);
                            end else begin
                                ser_state    <= SER_IDLE;
                                m_axis_tlast <= 1'b0;
                            end
                        end
                    end
                end
                default: ser_state <= SER_IDLE;
            endcase
        end
    end

    assign m_axis_tvalid = (ser_state == SER_BUSY);

endmodule
